// File: rtl/program_counter_fetch.sv
// rtl/program_counter_fetch.sv - instruction-fetch stage: program counter, fetch tracking and instruction register
module program_counter_fetch #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Stall_pm,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [INS_W-1:0]  ins_pm,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              ins_valid
);

    // fetch_vld/fetch_pc describe the word currently arriving on ins_pm
    logic              fetch_vld;
    logic [ADDR_W-1:0] fetch_pc;

    logic [ADDR_W-1:0] pc_rewind;
    logic [ADDR_W-1:0] pc_next_seq;

    // A stall discards the in-flight word, so the PC is rewound to re-issue it
    assign pc_rewind   = fetch_vld ? fetch_pc : pc_addr;
    assign pc_next_seq = pc_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_addr   <= '0;
            fetch_pc  <= '0;
            fetch_vld <= 1'b0;
            ins       <= '0;
            ins_pc    <= '0;
            ins_valid <= 1'b0;
        end else if (Stall) begin
            pc_addr   <= pc_rewind;
            fetch_vld <= 1'b0;
        end else if (Stall_pm) begin
            pc_addr   <= pc_rewind;
            fetch_vld <= 1'b0;
            ins       <= '0;
            ins_valid <= 1'b0;
        end else if (jump_en) begin
            pc_addr   <= jump_addr;
            fetch_vld <= 1'b0;
            ins       <= '0;
            ins_valid <= 1'b0;
        end else begin
            pc_addr   <= pc_next_seq;
            fetch_pc  <= pc_addr;
            fetch_vld <= 1'b1;
            if (fetch_vld) begin
                ins       <= ins_pm;
                ins_pc    <= fetch_pc;
                ins_valid <= 1'b1;
            end else begin
                ins       <= '0;
                ins_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_program_counter_fetch.sv
// tb/tb_program_counter_fetch.sv - directed self-checking bench for program_counter_fetch
module tb_program_counter_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Stall_pm = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_addr = 8'h00;
    logic [23:0] ins_pm = 24'h000000;
    logic [7:0]  pc_addr;
    logic [23:0] ins;
    logic [7:0]  ins_pc;
    logic        ins_valid;

    logic [23:0] mem [256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ins_pm <= mem[pc_addr];

    program_counter_fetch #(.ADDR_W(8), .INS_W(24)) dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .Stall_pm  (Stall_pm),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .ins_pm    (ins_pm),
        .pc_addr   (pc_addr),
        .ins       (ins),
        .ins_pc    (ins_pc),
        .ins_valid (ins_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the stream with ins = mem[0], ins_pc = 0 just sampled
    task automatic restart;
        reset = 1'b1;
        Stall = 1'b0;
        Stall_pm = 1'b0;
        jump_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (pc_addr !== 8'h00 || ins !== 24'h0 || ins_pc !== 8'h00 || ins_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: pc_addr=%h ins=%h ins_pc=%h ins_valid=%b required 00/000000/00/0",
                     pc_addr, ins, ins_pc, ins_valid);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (pc_addr !== 8'h01 || ins_valid !== 1'b0) begin
            fails++;
            $display("FAIL first_edge: pc_addr=%h ins_valid=%b required 01/0", pc_addr, ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h100000 || ins_pc !== 8'h00 || ins_valid !== 1'b1) begin
            fails++;
            $display("FAIL first_ins: ins=%h ins_pc=%h ins_valid=%b required 100000/00/1", ins, ins_pc, ins_valid);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] prev_pc;
        logic [7:0] e;
        bit seen_wrap = 1'b0;
        e = 8'h00;
        for (int i = 0; i < 260; i++) begin
            prev_pc = pc_addr;
            tick();
            e = e + 8'h01;
            if (prev_pc == 8'hFF) begin
                seen_wrap = 1'b1;
                tests++;
                if (pc_addr !== 8'h00) begin
                    fails++;
                    $display("FAIL pc_wrap: pc_addr=%h required 00", pc_addr);
                end
            end
            tests++;
            if (ins_pc !== e || ins !== mem[e] || ins_valid !== 1'b1) begin
                fails++;
                $display("FAIL seq_step%0d: ins_pc=%h ins=%h ins_valid=%b required %h/%h/1",
                         i, ins_pc, ins, ins_valid, e, mem[e]);
            end
        end
        tests++;
        if (!seen_wrap) begin
            fails++;
            $display("FAIL wrap_seen: no pc_addr FF->00 transition observed, required one");
        end
    endtask

    task automatic test_stall;
        restart();
        repeat (5) tick();
        tests++;
        if (ins !== 24'h100005 || ins_pc !== 8'h05) begin
            fails++;
            $display("FAIL stall_setup: ins=%h ins_pc=%h required 100005/05", ins, ins_pc);
        end
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (ins !== 24'h100005 || ins_pc !== 8'h05 || ins_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold%0d: ins=%h ins_pc=%h ins_valid=%b required 100005/05/1",
                         k, ins, ins_pc, ins_valid);
            end
        end
        Stall = 1'b0;
        tick();
        tests++;
        if (ins_valid !== 1'b0 || ins !== 24'h0) begin
            fails++;
            $display("FAIL stall_bubble: ins=%h ins_valid=%b required 000000/0", ins, ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h100006 || ins_pc !== 8'h06 || ins_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_resume: ins=%h ins_pc=%h ins_valid=%b required 100006/06/1", ins, ins_pc, ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h100007 || ins_pc !== 8'h07) begin
            fails++;
            $display("FAIL stall_next: ins=%h ins_pc=%h required 100007/07", ins, ins_pc);
        end
    endtask

    task automatic test_stall_pm;
        mem[4] = 24'ha00000;
        restart();
        repeat (4) tick();
        tests++;
        if (ins !== 24'ha00000 || ins_pc !== 8'h04) begin
            fails++;
            $display("FAIL pm_setup: ins=%h ins_pc=%h required a00000/04", ins, ins_pc);
        end
        Stall_pm = 1'b1;
        tick();
        Stall_pm = 1'b0;
        tests++;
        if (ins !== 24'h0 || ins_valid !== 1'b0 || ins_pc !== 8'h04) begin
            fails++;
            $display("FAIL pm_bubble: ins=%h ins_valid=%b ins_pc=%h required 000000/0/04", ins, ins_valid, ins_pc);
        end
        tick();
        tests++;
        if (ins_valid !== 1'b0) begin
            fails++;
            $display("FAIL pm_refetch_bubble: ins_valid=%b required 0", ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h100005 || ins_pc !== 8'h05 || ins_valid !== 1'b1) begin
            fails++;
            $display("FAIL pm_resume: ins=%h ins_pc=%h ins_valid=%b required 100005/05/1", ins, ins_pc, ins_valid);
        end
        mem[4] = 24'h100004;
    endtask

    task automatic test_jump;
        restart();
        repeat (7) tick();
        jump_en = 1'b1;
        jump_addr = 8'h40;
        tick();
        jump_en = 1'b0;
        tests++;
        if (pc_addr !== 8'h40 || ins !== 24'h0 || ins_valid !== 1'b0) begin
            fails++;
            $display("FAIL jump_edge: pc_addr=%h ins=%h ins_valid=%b required 40/000000/0", pc_addr, ins, ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h0 || ins_valid !== 1'b0) begin
            fails++;
            $display("FAIL jump_bubble2: ins=%h ins_valid=%b required 000000/0", ins, ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h100040 || ins_pc !== 8'h40 || ins_valid !== 1'b1) begin
            fails++;
            $display("FAIL jump_target: ins=%h ins_pc=%h ins_valid=%b required 100040/40/1", ins, ins_pc, ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h100041 || ins_pc !== 8'h41) begin
            fails++;
            $display("FAIL jump_follow: ins=%h ins_pc=%h required 100041/41", ins, ins_pc);
        end
    endtask

    task automatic test_priority;
        restart();
        repeat (3) tick();
        Stall = 1'b1;
        jump_en = 1'b1;
        jump_addr = 8'h80;
        tick();
        tests++;
        if (pc_addr !== 8'h04 || ins_pc !== 8'h03 || ins_valid !== 1'b1) begin
            fails++;
            $display("FAIL prio_stall_jump: pc_addr=%h ins_pc=%h ins_valid=%b required 04/03/1",
                     pc_addr, ins_pc, ins_valid);
        end
        Stall = 1'b0;
        jump_en = 1'b0;
        tick();
        tests++;
        if (ins_valid !== 1'b0 || pc_addr !== 8'h05) begin
            fails++;
            $display("FAIL prio_release: ins_valid=%b pc_addr=%h required 0/05", ins_valid, pc_addr);
        end
        tick();
        tests++;
        if (ins !== 24'h100004 || ins_pc !== 8'h04 || ins_valid !== 1'b1) begin
            fails++;
            $display("FAIL prio_resume: ins=%h ins_pc=%h ins_valid=%b required 100004/04/1", ins, ins_pc, ins_valid);
        end
    endtask

    task automatic test_reset_in_stall;
        restart();
        repeat (3) tick();
        Stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if (pc_addr !== 8'h00 || ins !== 24'h0 || ins_pc !== 8'h00 || ins_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_stall: pc_addr=%h ins=%h ins_pc=%h ins_valid=%b required 00/000000/00/0",
                     pc_addr, ins, ins_pc, ins_valid);
        end
        reset = 1'b0;
        Stall = 1'b0;
        tick();
        tests++;
        if (pc_addr !== 8'h01 || ins_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_restart_pc: pc_addr=%h ins_valid=%b required 01/0", pc_addr, ins_valid);
        end
        tick();
        tests++;
        if (ins !== 24'h100000 || ins_pc !== 8'h00 || ins_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_restart_ins: ins=%h ins_pc=%h ins_valid=%b required 100000/00/1", ins, ins_pc, ins_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 24'h100000 + 24'(i);
        test_reset();
        test_wrap();
        test_stall();
        test_stall_pm();
        test_jump();
        test_priority();
        test_reset_in_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_counter_fetch.md
# program_counter_fetch

Instruction-fetch stage of the 8-bit pipelined processor. Holds the program counter, drives the synchronous program-memory address, and registers each returned 24-bit word into `ins`, which feeds the stall control block and the decoder. It consumes `Stall` (freeze) and `Stall_pm` (bubble) from the stall control block, plus a jump request from decode. It re-issues any fetch that a stall or jump would otherwise lose.

## Interface
- `ADDR_W`, 8, program-memory address width
- `INS_W`, 24, instruction width
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `Stall`  in  1  freeze fetch and hold `ins`
- `Stall_pm`  in  1  hold fetch and inject a NOP bubble into `ins`
- `jump_en`  in  1  redirect fetch to `jump_addr` (from decode)
- `jump_addr`  in  ADDR_W  jump target
- `ins_pm`  in  INS_W  program-memory read data; equals mem[address presented the previous cycle]
- `pc_addr`  out  ADDR_W  program-memory read address (registered)
- `ins`  out  INS_W  fetched instruction to stall control / decode (registered)
- `ins_pc`  out  ADDR_W  address of the word currently in `ins`
- `ins_valid`  out  1  `ins` holds a real fetched instruction (0 = bubble)

## Operation
- Internal registers: `fetch_vld` (the data on `ins_pm` this cycle belongs to a live fetch) and `fetch_pc` (address of that data).
- Per-edge priority: reset > `Stall` > `Stall_pm` > `jump_en` > sequential.
- Reset: `pc_addr`=0, `fetch_pc`=0, `fetch_vld`=0, `ins`=24'h000000, `ins_pc`=0, `ins_valid`=0.
- `Stall`=1:
  - `ins`, `ins_pc` and `ins_valid` hold.
  - If `fetch_vld`: `pc_addr` <= `fetch_pc`, which rewinds and re-issues the in-flight address. Otherwise `pc_addr` holds.
  - `fetch_vld` <= 0.
- `Stall_pm`=1 (and `Stall`=0):
  - Same PC/rewind behaviour as `Stall`.
  - `ins` <= 24'h000000, `ins_valid` <= 0, `ins_pc` holds.
- `jump_en`=1 (no stall):
  - `pc_addr` <= `jump_addr`, `fetch_vld` <= 0, `fetch_pc` holds.
  - `ins` <= 0, `ins_valid` <= 0, squashing the wrong-path word on `ins_pm`.
- Sequential:
  - `pc_addr` <= `pc_addr`+1, modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
  - `fetch_pc` <= `pc_addr`, `fetch_vld` <= 1.
  - If `fetch_vld`: `ins` <= `ins_pm`, `ins_pc` <= `fetch_pc`, `ins_valid` <= 1.
  - Otherwise: `ins` <= 0, `ins_valid` <= 0.
- `jump_en` asserted together with `Stall` or `Stall_pm` is ignored. Decode must re-assert it after the stall.
- The block never decodes `ins`. Halt behaviour comes entirely from `Stall`.

## Timing
- Fetch latency, address to `ins`: 2 cycles. Address A is presented at edge n, data on `ins_pm` during cycle n+1, and `ins`=mem[A] after edge n+2.
- After reset deasserts (first free edge E0):
  - `pc_addr`=1 after E0.
  - `ins`=mem[0], `ins_valid`=1 after E1.
  - Throughput is then 1 instruction/cycle.
- Jump penalty: 2 bubbles.
  - Edge J: `pc_addr`=T, `ins`=0.
  - Edge J+1: `ins`=0.
  - Edge J+2: `ins`=mem[T], `ins_pc`=T.
- Stall of k cycles on a running stream: no instruction is lost or duplicated.
  - `ins` stays constant for k cycles.
  - 1 extra bubble follows release, because the re-issued fetch needs 1 cycle.
- `Stall_pm` pulse of 1 cycle: exactly 1 bubble from the pulse, plus the 1-cycle refetch bubble. The next valid `ins` is the word that was in flight.
- Reset asserted mid-stream, mid-stall or mid-jump: all outputs reach their reset values at that edge, with no residue.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset/sequence: memory word = 24'h100000 + addr. Release reset → `ins` = 24'h100000, 24'h100001, 24'h100002… on consecutive cycles, `ins_pc` = 0,1,2…, `ins_valid`=1 from the 2nd edge after release.
- Wrap: run 260 cycles → `pc_addr` goes 8'hFF→8'h00; `ins_pc` follows FF→00 with no bubble.
- Stall: assert `Stall` for 3 cycles while `ins`=24'h100005 → `ins` holds 24'h100005 for 3 cycles, then `ins_valid`=0 for 1 cycle, then 24'h100006. No gap or repeat in the `ins_pc` sequence.
- Stall_pm: 1-cycle pulse while `ins`=24'ha00000 at `ins_pc`=4 → next cycle `ins`=0 with `ins_valid`=0, then one more bubble, then `ins_pc`=5 with its correct word.
- Jump: `jump_en`=1, `jump_addr`=8'h40 while `ins_pc`=7 → 2 cycles with `ins_valid`=0, then `ins_pc`=8'h40 with `ins`=mem[8'h40]. Words 8 and 9 never appear.
- Priority/reset: `jump_en` together with `Stall` → jump ignored and `pc_addr` rewinds. `reset` asserted during an active `Stall` → all outputs zero on the next edge and fetch restarts at address 0.
